// File: rtl/regfile_pkg.sv
// Shared types and constants for the 2R1W register file and its flush sequencer.
package regfile_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } flush_state_e;

    localparam int READ_LAT_COMB = 0;
    localparam int READ_LAT_REG  = 1;

endpackage

// File: rtl/flush_sequencer.sv
// Flush sweep controller: walks a pointer over every entry once per flush request,
// asserting busy and a zeroing write strobe for the duration of the sweep.
module flush_sequencer
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              i_clock,
    input  logic              i_clear,
    input  logic              i_flush,
    output logic              o_busy,
    output logic              o_sweep_we,
    output logic [ADDR_W-1:0] o_sweep_addr
);

    flush_state_e      r_state;
    flush_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_last;

    assign w_last = (r_ptr == {ADDR_W{1'b1}});

    // State and pointer registers
    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_state <= IDLE;
            r_ptr   <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next state: a flush seen while sweeping is ignored, the sweep never restarts
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (i_flush) begin
                    w_state_nxt = SWEEP;
                    w_ptr_nxt   = {ADDR_W{1'b0}};
                end else begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = r_ptr;
                end
            end
            SWEEP: begin
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (w_last) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SWEEP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Outputs decoded straight from the state register
    always_comb begin
        o_busy       = 1'b0;
        o_sweep_we   = 1'b0;
        o_sweep_addr = r_ptr;
        case (r_state)
            SWEEP: begin
                o_busy     = 1'b1;
                o_sweep_we = 1'b1;
            end
            IDLE: begin
                o_busy     = 1'b0;
                o_sweep_we = 1'b0;
            end
            default: begin
                o_busy     = 1'b0;
                o_sweep_we = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with write-through bypass, optional hardwired-zero
// entry 0, selectable read latency and a sequenced flush.
module reg_file_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int READ_LAT = READ_LAT_COMB,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] Caddr,
    input  logic [DATA_W-1:0] C,
    input  logic [ADDR_W-1:0] Aaddr,
    input  logic [ADDR_W-1:0] Baddr,
    input  logic              flush,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_busy;
    logic              w_sweep_we;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_byp_en;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    flush_sequencer #(
        .ADDR_W (ADDR_W)
    ) u_flush_seq (
        .i_clock      (clock),
        .i_clear      (clear),
        .i_flush      (flush),
        .o_busy       (w_busy),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr)
    );

    assign busy     = w_busy;
    assign w_byp_en = load && !w_busy;
    assign w_wr_en  = w_byp_en && !((ZERO_REG != 0) && (Caddr == {ADDR_W{1'b0}}));

    // Storage array; the sweep owns the write port while it runs
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_sweep_we) begin
            r_mem[w_sweep_addr] <= {DATA_W{1'b0}};
        end else if (w_wr_en) begin
            r_mem[Caddr] <= C;
        end
    end

    // Read muxes: hardwired zero, then same-cycle write bypass, then array contents
    always_comb begin
        if ((ZERO_REG != 0) && (Aaddr == {ADDR_W{1'b0}})) begin
            w_rd_a = {DATA_W{1'b0}};
        end else if (w_byp_en && (Caddr == Aaddr)) begin
            w_rd_a = C;
        end else begin
            w_rd_a = r_mem[Aaddr];
        end

        if ((ZERO_REG != 0) && (Baddr == {ADDR_W{1'b0}})) begin
            w_rd_b = {DATA_W{1'b0}};
        end else if (w_byp_en && (Caddr == Baddr)) begin
            w_rd_b = C;
        end else begin
            w_rd_b = r_mem[Baddr];
        end
    end

    generate
        if (READ_LAT == READ_LAT_REG) begin : g_rd_reg
            logic [DATA_W-1:0] r_a;
            logic [DATA_W-1:0] r_b;

            // Registered read outputs
            always_ff @(posedge clock or posedge clear) begin
                if (clear) begin
                    r_a <= {DATA_W{1'b0}};
                    r_b <= {DATA_W{1'b0}};
                end else begin
                    r_a <= w_rd_a;
                    r_b <= w_rd_b;
                end
            end

            assign A = r_a;
            assign B = r_b;
        end else begin : g_rd_comb
            assign A = w_rd_a;
            assign B = w_rd_b;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed scoreboard bench driving two register-file configurations in parallel:
// dut0 = combinational reads with zero entry, dut1 = registered reads, ordinary entry 0.
module tb_reg_file_2r1w;

    logic        clock = 1'b0;
    logic        clear;
    logic        load;
    logic        flush;
    logic [3:0]  caddr;
    logic [3:0]  aaddr;
    logic [3:0]  baddr;
    logic [15:0] c;
    logic [15:0] a0, b0, a1, b1;
    logic        busy0, busy1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       tag;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clock = ~clock;

    reg_file_2r1w #(.DATA_W(16), .ADDR_W(4), .READ_LAT(0), .ZERO_REG(1)) u_dut0 (
        .clock(clock), .clear(clear), .load(load), .Caddr(caddr), .C(c),
        .Aaddr(aaddr), .Baddr(baddr), .flush(flush), .A(a0), .B(b0), .busy(busy0)
    );

    reg_file_2r1w #(.DATA_W(16), .ADDR_W(4), .READ_LAT(1), .ZERO_REG(0)) u_dut1 (
        .clock(clock), .clear(clear), .load(load), .Caddr(caddr), .C(c),
        .Aaddr(aaddr), .Baddr(baddr), .flush(flush), .A(a1), .B(b1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [15:0] ea0, input logic [15:0] eb0,
                        input logic [15:0] ea1, input logic [15:0] eb1);
        exp_t e;
        e.tag = tag; e.a = ea0; e.b = eb0; q0.push_back(e);
        e.a = ea1; e.b = eb1; q1.push_back(e);
    endtask

    // dut0 answers within the cycle, dut1 after the next rising edge
    task automatic cyc();
        exp_t e;
        #2;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check({e.tag, "/A0"}, a0, e.a);
            check({e.tag, "/B0"}, b0, e.b);
        end
        @(posedge clock);
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check({e.tag, "/A1"}, a1, e.a);
            check({e.tag, "/B1"}, b1, e.b);
        end
    endtask

    task automatic check_busy(input string tag, input logic exp);
        check({tag, "/busy0"}, busy0, exp);
        check({tag, "/busy1"}, busy1, exp);
    endtask

    initial begin
        logic [15:0] ea0, ea1, eb;
        clear = 1'b1; load = 1'b0; flush = 1'b0;
        caddr = 4'd0; c = 16'h0000; aaddr = 4'd5; baddr = 4'd9;

        // reset state
        @(posedge clock); #1;
        check_busy("rst", 1'b0);
        check("rst/A0", a0, 16'h0000); check("rst/B0", b0, 16'h0000);
        check("rst/A1", a1, 16'h0000); check("rst/B1", b1, 16'h0000);
        clear = 1'b0;
        push("rst_rd", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        cyc();

        // plain write then read
        load = 1'b1; caddr = 4'd1; c = 16'h4BC5;
        cyc();
        load = 1'b0; aaddr = 4'd1; baddr = 4'd1;
        push("wr1", 16'h4BC5, 16'h4BC5, 16'h4BC5, 16'h4BC5);
        cyc();

        // same-cycle bypass on both ports, then committed value
        load = 1'b1; caddr = 4'd2; c = 16'h4BC7; aaddr = 4'd2; baddr = 4'd2;
        push("byp2", 16'h4BC7, 16'h4BC7, 16'h4BC7, 16'h4BC7);
        cyc();
        load = 1'b0;
        push("rd2", 16'h4BC7, 16'h4BC7, 16'h4BC7, 16'h4BC7);
        cyc();

        // bypass on B only
        load = 1'b1; caddr = 4'd7; c = 16'h1234; aaddr = 4'd1; baddr = 4'd7;
        push("bypB", 16'h4BC5, 16'h1234, 16'h4BC5, 16'h1234);
        cyc();

        // entry 0: hardwired in dut0, ordinary in dut1
        caddr = 4'd0; c = 16'hFFFF; aaddr = 4'd0; baddr = 4'd3;
        push("z_byp", 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
        cyc();
        load = 1'b0;
        push("z_rd", 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
        cyc();

        // fill every entry with 0x1000+i
        for (int i = 0; i < 16; i++) begin
            load = 1'b1; caddr = 4'(i); c = 16'h1000 | {12'h000, 4'(i)};
            aaddr = 4'(i); baddr = 4'(i);
            ea0 = (i == 0) ? 16'h0000 : (16'h1000 | {12'h000, 4'(i)});
            push($sformatf("fill%0d", i), ea0, ea0, c, c);
            cyc();
        end

        // flush request; the load in the same cycle commits and is later erased
        flush = 1'b1; load = 1'b1; caddr = 4'd3; c = 16'hABCD;
        cyc();
        flush = 1'b0;

        // sweep: dropped loads, no bypass, a second flush ignored
        for (int j = 0; j < 16; j++) begin
            aaddr = 4'(j); baddr = 4'(j - 1);
            load = 1'b1; caddr = 4'(j - 1); c = 16'h5555;
            flush = (j == 2);
            if (j == 3) begin
                ea0 = 16'hABCD; ea1 = 16'hABCD;
            end else if (j == 0) begin
                ea0 = 16'h0000; ea1 = 16'h1000;
            end else begin
                ea0 = 16'h1000 | {12'h000, 4'(j)}; ea1 = ea0;
            end
            eb = (j == 0) ? 16'h100F : 16'h0000;
            check_busy($sformatf("sweep%0d", j), 1'b1);
            push($sformatf("sweep%0d", j), ea0, eb, ea1, eb);
            cyc();
        end
        load = 1'b0; flush = 1'b0;
        check_busy("sweep_end", 1'b0);

        for (int i = 0; i < 16; i++) begin
            aaddr = 4'(i); baddr = 4'(15 - i);
            push($sformatf("flushed%0d", i), 16'h0000, 16'h0000, 16'h0000, 16'h0000);
            cyc();
        end

        // asynchronous clear in the middle of a sweep
        load = 1'b1; caddr = 4'd9; c = 16'h2222;
        cyc();
        load = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0; aaddr = 4'd9; baddr = 4'd9;
        for (int j = 0; j < 5; j++) cyc();
        check("preclr/A0", a0, 16'h2222);
        check("preclr/A1", a1, 16'h2222);
        #1 clear = 1'b1;
        #1;
        check_busy("midclr", 1'b0);
        check("midclr/A0", a0, 16'h0000); check("midclr/B0", b0, 16'h0000);
        check("midclr/A1", a1, 16'h0000); check("midclr/B1", b1, 16'h0000);
        #1 clear = 1'b0;
        push("postclr", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        cyc();
        check_busy("postclr", 1'b0);

        // a new flush sweeps again from entry 0
        load = 1'b1; caddr = 4'd1; c = 16'h3333;
        cyc();
        caddr = 4'd15; c = 16'h7777;
        cyc();
        load = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        check_busy("rs0", 1'b1);
        cyc();
        aaddr = 4'd1; baddr = 4'd15;
        push("rs1", 16'h3333, 16'h7777, 16'h3333, 16'h7777);
        cyc();
        push("rs2", 16'h0000, 16'h7777, 16'h0000, 16'h7777);
        cyc();
        for (int j = 3; j < 16; j++) begin
            check_busy($sformatf("rs%0d", j), 1'b1);
            cyc();
        end
        check_busy("rs_end", 1'b0);
        push("rs_done", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
